// File: rtl/spi_slave_pkg.sv
// Shared state encoding, opcodes, lane encodings and bit-count helpers
// for the SPI slave burst controller.
package spi_slave_pkg;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA_RX,
        ST_DATA_TX,
        ST_ERROR
    } state_t;

    localparam logic [7:0] CMD_WR      = 8'h02;
    localparam logic [7:0] CMD_RD      = 8'h03;
    localparam logic [7:0] CMD_FAST_RD = 8'h0B;

    localparam logic [1:0] LANE_SINGLE = 2'b00;
    localparam logic [1:0] LANE_DUAL   = 2'b01;
    localparam logic [1:0] LANE_QUAD   = 2'b10;

    // Registered one-cycle strobes towards the shift registers and the plug.
    typedef struct packed {
        logic rx_upd;
        logic tx_upd;
        logic tx_valid;
        logic addr_valid;
        logic tx_ready;
    } strobe_t;

    function automatic logic [1:0] lane_sanitize(input logic [1:0] mode);
        return (mode == 2'b11) ? LANE_SINGLE : mode;
    endfunction

    // Shift-register load value for an n-bit field over the active lanes.
    function automatic logic [7:0] cnt(input int unsigned nbits, input logic [1:0] mode);
        int unsigned lanes;
        case (lane_sanitize(mode))
            LANE_DUAL: lanes = 2;
            LANE_QUAD: lanes = 4;
            default:   lanes = 1;
        endcase
        return 8'(nbits / lanes - 1);
    endfunction

endpackage

// File: rtl/spi_slave_burst_ctrl_addr_gen.sv
// Beat address register: loads the decoded address, then advances one beat
// at a time, optionally wrapping inside a power-of-two window.
module spi_slave_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int STEP       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  advance,
    input  logic [15:0]           wrap_length,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] sum;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Wrapping keeps the bits above the window and lets only the low bits roll over.
    always_comb begin
        mask      = ADDR_WIDTH'(wrap_length - 16'd1);
        sum       = addr + ADDR_WIDTH'(STEP);
        next_addr = (wrap_length == 16'd0) ? sum : ((addr & ~mask) | (sum & mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          addr <= '0;
        else if (load)    addr <= load_addr;
        else if (advance) addr <= next_addr;
    end

endmodule

// File: rtl/spi_slave_burst_ctrl.sv
// SPI slave protocol FSM: decodes CMD/ADDR/DUMMY/DATA phases, programs the
// rx/tx shift-register bit counters and streams burst beats to/from the plug.
module spi_slave_burst_ctrl
    import spi_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] UNDERRUN_PAT = DATA_WIDTH'(32'hDEADBEEF)
) (
    input  logic                  sclk,
    input  logic                  cs,
    input  logic [1:0]            lane_mode,
    input  logic [7:0]            dummy_cycles,
    input  logic [15:0]           wrap_length,
    output logic [7:0]            rx_counter,
    output logic                  rx_counter_upd,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_data_valid,
    output logic [7:0]            tx_counter,
    output logic                  tx_counter_upd,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_done,
    output logic [1:0]            pad_mode,
    output logic                  pad_dir,
    output logic                  ctrl_rd_wr,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic                  ctrl_addr_valid,
    output logic [DATA_WIDTH-1:0] ctrl_data_rx,
    output logic                  ctrl_data_rx_valid,
    input  logic                  ctrl_data_rx_ready,
    input  logic [DATA_WIDTH-1:0] ctrl_data_tx,
    input  logic                  ctrl_data_tx_valid,
    output logic                  ctrl_data_tx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  cmd_error
);

    state_t                state_q, state_n;
    strobe_t               stb_q, stb_n;
    logic [7:0]            rx_cnt_q, rx_cnt_n;
    logic [7:0]            tx_cnt_q, tx_cnt_n;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_n;
    logic                  rd_q, rd_n;
    logic                  fast_q, fast_n;
    logic                  overrun_q, overrun_n;
    logic                  underrun_q, underrun_n;
    logic                  cmd_err_q, cmd_err_n;
    logic                  addr_load, addr_adv, tx_load;
    logic [1:0]            mode;

    assign mode = lane_sanitize(lane_mode);

    always_comb begin
        state_n    = state_q;
        stb_n      = '0;
        rx_cnt_n   = rx_cnt_q;
        tx_cnt_n   = tx_cnt_q;
        tx_data_n  = tx_data_q;
        rd_n       = rd_q;
        fast_n     = fast_q;
        overrun_n  = overrun_q;
        underrun_n = underrun_q;
        cmd_err_n  = cmd_err_q;
        addr_load  = 1'b0;
        addr_adv   = 1'b0;
        tx_load    = 1'b0;

        case (state_q)
            ST_CMD: if (rx_data_valid) begin
                case (rx_data[7:0])
                    CMD_WR, CMD_RD, CMD_FAST_RD: begin
                        state_n      = ST_ADDR;
                        rx_cnt_n     = cnt(ADDR_WIDTH, mode);
                        stb_n.rx_upd = 1'b1;
                        rd_n         = (rx_data[7:0] != CMD_WR);
                        fast_n       = (rx_data[7:0] == CMD_FAST_RD);
                    end
                    default: begin
                        state_n   = ST_ERROR;
                        cmd_err_n = 1'b1;
                    end
                endcase
            end
            ST_ADDR: if (rx_data_valid) begin
                addr_load        = 1'b1;
                stb_n.addr_valid = 1'b1;
                if (!rd_q) begin
                    state_n      = ST_DATA_RX;
                    rx_cnt_n     = cnt(DATA_WIDTH, mode);
                    stb_n.rx_upd = 1'b1;
                end else begin
                    // Request the first read word now so it can arrive during the dummy phase.
                    stb_n.tx_ready = 1'b1;
                    if (fast_q && dummy_cycles != 8'd0) begin
                        state_n      = ST_DUMMY;
                        rx_cnt_n     = dummy_cycles - 8'd1;
                        stb_n.rx_upd = 1'b1;
                    end else begin
                        state_n = ST_DATA_TX;
                        tx_load = 1'b1;
                    end
                end
            end
            ST_DUMMY: if (rx_data_valid) begin
                state_n = ST_DATA_TX;
                tx_load = 1'b1;
            end
            ST_DATA_RX: if (rx_data_valid) begin
                stb_n.rx_upd     = 1'b1;
                stb_n.addr_valid = 1'b1;
                addr_adv         = 1'b1;
                if (!ctrl_data_rx_ready) overrun_n = 1'b1;
            end
            ST_DATA_TX: if (tx_done) begin
                tx_load          = 1'b1;
                stb_n.tx_ready   = 1'b1;
                stb_n.addr_valid = 1'b1;
                addr_adv         = 1'b1;
            end
            default: ;
        endcase

        // Every tx word load: fresh count plus either plug data or the underrun filler.
        if (tx_load) begin
            stb_n.tx_upd   = 1'b1;
            stb_n.tx_valid = 1'b1;
            tx_cnt_n       = cnt(DATA_WIDTH, mode);
            if (ctrl_data_tx_valid) begin
                tx_data_n = ctrl_data_tx;
            end else begin
                tx_data_n  = UNDERRUN_PAT;
                underrun_n = 1'b1;
            end
        end
    end

    always_ff @(posedge sclk or posedge cs) begin
        if (cs) begin
            state_q    <= ST_CMD;
            stb_q      <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            tx_data_q  <= '0;
            rd_q       <= 1'b0;
            fast_q     <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            stb_q      <= stb_n;
            rx_cnt_q   <= rx_cnt_n;
            tx_cnt_q   <= tx_cnt_n;
            tx_data_q  <= tx_data_n;
            rd_q       <= rd_n;
            fast_q     <= fast_n;
            overrun_q  <= overrun_n;
            underrun_q <= underrun_n;
            cmd_err_q  <= cmd_err_n;
        end
    end

    spi_slave_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STEP       (DATA_WIDTH / 8)
    ) u_addr_gen (
        .clk         (sclk),
        .rst         (cs),
        .load        (addr_load),
        .load_addr   (ADDR_WIDTH'(rx_data)),
        .advance     (addr_adv),
        .wrap_length (wrap_length),
        .addr        (ctrl_addr)
    );

    // The command count must be ready before the first bit, so it bypasses the register.
    assign rx_counter         = (state_q == ST_CMD) ? cnt(8, mode) : rx_cnt_q;
    assign rx_counter_upd     = stb_q.rx_upd;
    assign tx_counter         = tx_cnt_q;
    assign tx_counter_upd     = stb_q.tx_upd;
    assign tx_data            = tx_data_q;
    assign tx_data_valid      = stb_q.tx_valid;
    assign pad_mode           = mode;
    assign pad_dir            = (state_q != ST_DATA_TX);
    assign ctrl_rd_wr         = rd_q;
    assign ctrl_addr_valid    = stb_q.addr_valid;
    assign ctrl_data_rx       = rx_data;
    assign ctrl_data_rx_valid = (state_q == ST_DATA_RX) && rx_data_valid;
    assign ctrl_data_tx_ready = stb_q.tx_ready;
    assign rx_overrun         = overrun_q;
    assign tx_underrun        = underrun_q;
    assign cmd_error          = cmd_err_q;

endmodule

// File: tb/tb_spi_slave_burst_ctrl.sv
// Bench for spi_slave_burst_ctrl: transaction-level expectation queues built
// up front per burst, drained by a per-cycle compare process.
module tb_spi_slave_burst_ctrl;

    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam logic [31:0] PAT = 32'hDEADBEEF;

    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic [1:0]  lane_mode = 2'b00;
    logic [7:0]  dummy_cycles = 8'd0;
    logic [15:0] wrap_length = 16'd0;
    logic [7:0]  rx_counter, tx_counter;
    logic        rx_counter_upd, tx_counter_upd;
    logic [31:0] rx_data = 32'd0;
    logic        rx_data_valid = 1'b0;
    logic [31:0] tx_data;
    logic        tx_data_valid;
    logic        tx_done = 1'b0;
    logic [1:0]  pad_mode;
    logic        pad_dir, ctrl_rd_wr, ctrl_addr_valid, ctrl_data_rx_valid, ctrl_data_tx_ready;
    logic [31:0] ctrl_addr, ctrl_data_rx;
    logic        ctrl_data_rx_ready = 1'b1;
    logic [31:0] ctrl_data_tx = 32'd0;
    logic        ctrl_data_tx_valid = 1'b0;
    logic        rx_overrun, tx_underrun, cmd_error;

    always #5 sclk = ~sclk;

    spi_slave_burst_ctrl dut (
        .sclk(sclk), .cs(cs), .lane_mode(lane_mode), .dummy_cycles(dummy_cycles),
        .wrap_length(wrap_length), .rx_counter(rx_counter), .rx_counter_upd(rx_counter_upd),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid), .tx_counter(tx_counter),
        .tx_counter_upd(tx_counter_upd), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .tx_done(tx_done), .pad_mode(pad_mode), .pad_dir(pad_dir), .ctrl_rd_wr(ctrl_rd_wr),
        .ctrl_addr(ctrl_addr), .ctrl_addr_valid(ctrl_addr_valid), .ctrl_data_rx(ctrl_data_rx),
        .ctrl_data_rx_valid(ctrl_data_rx_valid), .ctrl_data_rx_ready(ctrl_data_rx_ready),
        .ctrl_data_tx(ctrl_data_tx), .ctrl_data_tx_valid(ctrl_data_tx_valid),
        .ctrl_data_tx_ready(ctrl_data_tx_ready), .rx_overrun(rx_overrun),
        .tx_underrun(tx_underrun), .cmd_error(cmd_error)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$], exp_wdata_q[$], exp_tx_q[$];
    logic [7:0]  exp_rxcnt_q[$];
    logic [7:0]  exp_txcnt;
    logic [31:0] obs_addr[$], obs_tx[$];
    logic [7:0]  obs_rxcnt[$], obs_txcnt[$];
    int          ready_cnt = 0;
    bit          exp_in_tx = 1'b0;
    bit          exp_rd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected strobe, value %0h", name, act);
    endtask

    function automatic logic [7:0] lcnt(input int n, input logic [1:0] m);
        int l;
        l = (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
        return 8'(n / l - 1);
    endfunction

    // Beat stride 4 bytes; with a window, stay inside the aligned window modulo its size.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [15:0] w);
        logic [31:0] base;
        if (w == 16'd0) return a + 32'd4;
        base = a - (a % {16'd0, w});
        return base + ((a - base + 32'd4) % {16'd0, w});
    endfunction

    always @(negedge sclk) begin
        check("pad_dir", pad_dir, !exp_in_tx);
        check("pad_mode", pad_mode, (lane_mode == 2'b11) ? 2'b00 : lane_mode);
        check("ctrl_rd_wr", ctrl_rd_wr, exp_rd);
        if (ctrl_addr_valid) begin
            obs_addr.push_back(ctrl_addr);
            if (exp_addr_q.size() == 0) unexpected("ctrl_addr_valid", ctrl_addr);
            else check("ctrl_addr", ctrl_addr, exp_addr_q.pop_front());
        end
        if (rx_counter_upd) begin
            obs_rxcnt.push_back(rx_counter);
            if (exp_rxcnt_q.size() == 0) unexpected("rx_counter_upd", 32'(rx_counter));
            else check("rx_counter", rx_counter, exp_rxcnt_q.pop_front());
        end
        if (tx_data_valid) begin
            obs_tx.push_back(tx_data);
            obs_txcnt.push_back(tx_counter);
            check("tx_counter_upd", tx_counter_upd, 1'b1);
            check("tx_counter", tx_counter, exp_txcnt);
            if (exp_tx_q.size() == 0) unexpected("tx_data_valid", tx_data);
            else check("tx_data", tx_data, exp_tx_q.pop_front());
        end
        if (ctrl_data_rx_valid) begin
            if (exp_wdata_q.size() == 0) unexpected("ctrl_data_rx_valid", ctrl_data_rx);
            else check("ctrl_data_rx", ctrl_data_rx, exp_wdata_q.pop_front());
        end
        if (ctrl_data_tx_ready) begin
            ready_cnt++;
            check("tx_ready_with_addr", ctrl_addr_valid, 1'b1);
        end
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic pulse_rx(input logic [31:0] d, input int gap);
        repeat (gap) step();
        rx_data       = d;
        rx_data_valid = 1'b1;
        step();
        rx_data_valid = 1'b0;
        rx_data       = $urandom;
    endtask

    function automatic int gap();
        return $urandom_range(0, 2);
    endfunction

    task automatic run_trans(input logic [7:0] op, input logic [1:0] mode, input logic [7:0] dummy,
                             input logic [15:0] wrap, input logic [31:0] addr, input int beats,
                             input int bad_pct, input bit abort);
        bit          legal, rd, fast, any_bad;
        logic [31:0] a, d;
        logic [31:0] words[$];
        bit          ok[$];
        obs_addr.delete(); obs_tx.delete(); obs_rxcnt.delete(); obs_txcnt.delete();
        ready_cnt = 0;
        legal = (op == 8'h02) || (op == 8'h03) || (op == 8'h0B);
        rd    = legal && (op != 8'h02);
        fast  = (op == 8'h0B);
        lane_mode = mode; dummy_cycles = dummy; wrap_length = wrap;
        exp_txcnt = lcnt(DW, mode);
        tx_done = 1'b0; ctrl_data_rx_ready = 1'b1; ctrl_data_tx_valid = 1'b0;
        step();
        cs = 1'b0;
        step();
        check("cmd_rx_counter", rx_counter, lcnt(8, mode));

        any_bad = 1'b0;
        if (legal) begin
            exp_rxcnt_q.push_back(lcnt(AW, mode));
            if (!rd) exp_rxcnt_q.push_back(lcnt(DW, mode));
            else if (fast && dummy != 8'd0) exp_rxcnt_q.push_back(dummy - 8'd1);
            a = addr;
            for (int k = 0; k < beats; k++) begin
                exp_addr_q.push_back(a);
                a = next_addr(a, wrap);
                words.push_back($urandom);
                ok.push_back($urandom_range(0, 99) >= bad_pct);
                if (!ok[k]) any_bad = 1'b1;
                if (rd) exp_tx_q.push_back(ok[k] ? words[k] : PAT);
                else begin
                    exp_wdata_q.push_back(words[k]);
                    exp_rxcnt_q.push_back(lcnt(DW, mode));
                end
            end
            if (!rd) exp_addr_q.push_back(a);
        end

        d = $urandom;
        d[7:0] = op;
        pulse_rx(d, gap());
        exp_rd = rd;

        if (!legal) begin
            pulse_rx($urandom, 1);
            pulse_rx($urandom, 0);
            step(); step();
            check("err_addr_strobes", obs_addr.size(), 0);
            check("err_rx_loads", obs_rxcnt.size(), 0);
            check("err_tx_loads", obs_tx.size(), 0);
        end else if (!rd) begin
            pulse_rx(addr, gap());
            for (int k = 0; k < beats; k++) begin
                ctrl_data_rx_ready = ok[k];
                pulse_rx(words[k], gap());
                ctrl_data_rx_ready = 1'b1;
            end
        end else begin
            if (fast && dummy != 8'd0) begin
                pulse_rx(addr, gap());
                ctrl_data_tx = words[0]; ctrl_data_tx_valid = ok[0];
                pulse_rx($urandom, gap());
            end else begin
                ctrl_data_tx = words[0]; ctrl_data_tx_valid = ok[0];
                pulse_rx(addr, gap());
            end
            exp_in_tx = 1'b1;
            for (int k = 1; k < beats; k++) begin
                repeat (gap()) step();
                ctrl_data_tx = words[k]; ctrl_data_tx_valid = ok[k];
                tx_done = 1'b1;
                step();
                tx_done = 1'b0;
            end
        end

        step(); step();
        check("addr_left", exp_addr_q.size(), 0);
        check("rxcnt_left", exp_rxcnt_q.size(), 0);
        check("tx_left", exp_tx_q.size(), 0);
        check("wdata_left", exp_wdata_q.size(), 0);
        check("tx_ready_pulses", ready_cnt, rd ? beats : 0);
        check("rx_overrun", rx_overrun, legal && !rd && any_bad);
        check("tx_underrun", tx_underrun, rd && any_bad);
        check("cmd_error", cmd_error, !legal);

        // Abort lands exactly on a would-be beat: no write strobe may escape.
        if (abort) begin
            rx_data = $urandom;
            rx_data_valid = 1'b1;
        end
        cs = 1'b1;
        exp_in_tx = 1'b0;
        exp_rd = 1'b0;
        step();
        rx_data_valid = 1'b0;
        check("rst_cmd_error", cmd_error, 1'b0);
        check("rst_rx_overrun", rx_overrun, 1'b0);
        check("rst_tx_underrun", tx_underrun, 1'b0);
        check("rst_ctrl_addr", ctrl_addr, 32'd0);
        check("rst_tx_data", tx_data, 32'd0);
        check("rst_tx_counter", tx_counter, 8'd0);
        check("rst_rx_counter", rx_counter, lcnt(8, mode));
        exp_addr_q.delete(); exp_rxcnt_q.delete(); exp_tx_q.delete(); exp_wdata_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        int         r;
        step(); step();
        check("reset_pad_dir", pad_dir, 1'b1);
        check("reset_ctrl_addr", ctrl_addr, 32'd0);
        check("reset_tx_data", tx_data, 32'd0);
        check("reset_flags", {rx_overrun, tx_underrun, cmd_error}, 3'b000);
        check("reset_strobes", {rx_counter_upd, tx_counter_upd, tx_data_valid, ctrl_addr_valid,
                                ctrl_data_tx_ready, ctrl_data_rx_valid}, 6'd0);
        check("reset_rd_wr", ctrl_rd_wr, 1'b0);
        check("reset_rx_counter", rx_counter, 8'd7);

        run_trans(8'h02, 2'b00, 8'd0, 16'd0, 32'h1000, 2, 0, 1'b0);
        check("wr_addr0", obs_addr[0], 32'h1000);
        check("wr_addr1", obs_addr[1], 32'h1004);
        check("wr_data_cnt", obs_rxcnt[1], 8'd31);

        run_trans(8'h0B, 2'b10, 8'd8, 16'd0, 32'h20, 2, 0, 1'b0);
        check("fast_addr_cnt", obs_rxcnt[0], 8'd7);
        check("fast_dummy_cnt", obs_rxcnt[1], 8'd7);
        check("fast_tx_cnt", obs_txcnt[0], 8'd7);

        run_trans(8'h03, 2'b01, 8'd0, 16'd8, 32'h104, 3, 0, 1'b0);
        check("wrap_addr0", obs_addr[0], 32'h104);
        check("wrap_addr1", obs_addr[1], 32'h100);
        check("wrap_addr2", obs_addr[2], 32'h104);

        run_trans(8'h55, 2'b00, 8'd0, 16'd0, 32'h0, 1, 0, 1'b0);

        run_trans(8'h03, 2'b00, 8'd0, 16'd0, 32'h40, 1, 100, 1'b0);
        check("underrun_pattern", obs_tx[0], 32'hDEADBEEF);

        run_trans(8'h02, 2'b00, 8'd0, 16'd0, 32'h80, 1, 100, 1'b0);
        run_trans(8'h02, 2'b01, 8'd0, 16'd0, 32'h200, 2, 0, 1'b1);
        run_trans(8'h03, 2'b00, 8'd0, 16'd0, 32'h300, 1, 0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r < 3) op = 8'h02;
            else if (r < 6) op = 8'h03;
            else if (r < 9) op = 8'h0B;
            else begin
                op = 8'($urandom);
                while (op == 8'h02 || op == 8'h03 || op == 8'h0B) op = 8'($urandom);
            end
            run_trans(op, 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12)),
                      ($urandom_range(0, 2) == 0) ? 16'd0 : 16'(1 << $urandom_range(2, 7)),
                      ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : 32'($urandom),
                      $urandom_range(1, 5), 25, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
